// File: rtl/hs_req_initiator.sv
// hs_req_initiator
// Four-phase req/ack handshake initiator. Accepts a one-cycle start command,
// latches the data word, raises req, waits for ack to rise and then to fall,
// and reports clean completion (done) or a phase timeout (timeout_err).
// Every output is a flop; no combinational path from ack or start.

module hs_req_initiator #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,   // cycles allowed per wait phase, >= 2
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              req,
    output logic [DATA_W-1:0] dout,
    input  logic              ack,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    // Timer value on the TIMEOUT-th consecutive waiting cycle of a phase.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic             abort;

    // Handshake sequencer: state, registered outputs, statistics counters.
    always_ff @(posedge clk) begin
        // NOTE: every register here, including the data latch, gets an explicit
        // reset value so a mid-transfer reset leaves no stale word on dout.
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            abort       <= 1'b0;
            req         <= 1'b0;
            busy        <= 1'b0;
            dout        <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            xfer_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge values and the pulse defaults below are overridable.
            done        <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dout  <= din;
                        timer <= '0;
                        abort <= 1'b0;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                        state <= ST_ASSERT;
                    end
                end

                ST_ASSERT: begin
                    if (ack) begin
                        req   <= 1'b0;
                        timer <= '0;
                        state <= ST_RELEASE;
                    end else if (timer == TMR_LAST) begin
                        // Consumer never answered: drop req and still wait for
                        // ack low, but remember not to report completion.
                        req         <= 1'b0;
                        timer       <= '0;
                        abort       <= 1'b1;
                        timeout_err <= 1'b1;
                        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
                        state       <= ST_RELEASE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (!ack) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        if (!abort) begin
                            done <= 1'b1;
                            if (xfer_cnt != CNT_MAX) xfer_cnt <= xfer_cnt + CNT_W'(1);
                        end
                    end else if (timer == TMR_LAST) begin
                        // ack stuck high: give up on this transfer.
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: begin
                    req   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_req_initiator.sv
// tb_hs_req_initiator
// Randomized handshake bench. For each transfer the driver picks an ack
// waveform (rise delay, high width), derives the event timeline from the
// handshake rules, and pushes the expected events into a scoreboard queue.
// An independent monitor watches req/busy edges and the done/timeout_err
// pulses and compares each against the queue head.

module tb_hs_req_initiator;

    localparam int DW     = 8;
    localparam int T      = 5;
    localparam int CW     = 3;
    localparam int MAXC   = (1 << CW) - 1;
    localparam int NUM_TX = 60;

    localparam int EV_RISE  = 0;  // req rises
    localparam int EV_FALL  = 1;  // req falls
    localparam int EV_DONE  = 2;  // done pulse
    localparam int EV_TERR  = 3;  // timeout_err pulse
    localparam int EV_BFALL = 4;  // busy falls

    typedef struct {
        int          kind;
        int          cyc;
        logic [DW-1:0] data;
        int          xfer;
        int          err;
        logic        busy;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] din;
    logic          busy;
    logic          req;
    logic [DW-1:0] dout;
    logic          ack;
    logic          done;
    logic          timeout_err;
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] err_cnt;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    hs_req_initiator #(.DATA_W(DW), .TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy),
        .req(req), .dout(dout), .ack(ack), .done(done),
        .timeout_err(timeout_err), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle k is the interval following the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [DW-1:0] d,
                           input int x, input int e, input logic b);
        ev_t ev;
        ev.kind = kind; ev.cyc = c; ev.data = d; ev.xfer = x; ev.err = e; ev.busy = b;
        exp_q.push_back(ev);
    endtask

    task automatic match_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", kind, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind",  kind, e.kind);
            check("ev_cycle", cyc, e.cyc);
            check("ev_dout",  32'(dout), 32'(e.data));
            check("ev_xfer",  32'(xfer_cnt), e.xfer);
            check("ev_err",   32'(err_cnt), e.err);
            check("ev_busy",  32'(busy), 32'(e.busy));
        end
    endtask

    // Monitor: sample mid-cycle, dispatch observed events in fixed order.
    initial begin
        logic req_q = 1'b0;
        logic busy_q = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done && timeout_err) check("done_and_terr", 1, 0);
                if (req && !req_q)   match_ev(EV_RISE);
                if (!req && req_q)   match_ev(EV_FALL);
                if (done)            match_ev(EV_DONE);
                if (timeout_err)     match_ev(EV_TERR);
                if (!busy && busy_q) match_ev(EV_BFALL);
            end
            req_q  = req;
            busy_q = busy;
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    initial begin
        int s, sn, a, w, ack_a, r, l, f, xfer_m, err_m;
        bit abort_m;
        logic [DW-1:0] d;

        // Reset held 3 cycles with start and ack asserted: outputs stay reset.
        rst = 1'b1; start = 1'b1; ack = 1'b1; din = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_req",  32'(req), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_dout", 32'(dout), 0);
            check("rst_done", 32'(done), 0);
            check("rst_terr", 32'(timeout_err), 0);
            check("rst_xfer", 32'(xfer_cnt), 0);
            check("rst_err",  32'(err_cnt), 0);
        end
        rst = 1'b0; start = 1'b0; ack = 1'b0; din = '0;
        @(posedge clk); #1;
        check("idle_req", 32'(req), 0);

        // Randomized transfers scored against the event-timeline model.
        mon_en = 1'b1;
        xfer_m = 0; err_m = 0;
        s = cyc + 2;
        for (int i = 0; i < NUM_TX; i++) begin
            a = $urandom_range(0, T + 1);       // ack rises a cycles after req
            w = $urandom_range(1, T + 2);       // ack stays high w cycles
            d = DW'($urandom);
            ack_a = s + 1 + a;

            push_ev(EV_RISE, s + 1, d, xfer_m, err_m, 1'b1);
            if (a < T) begin
                r = s + 2 + a;
                abort_m = 1'b0;
                push_ev(EV_FALL, r, d, xfer_m, err_m, 1'b1);
            end else begin
                r = s + 1 + T;
                abort_m = 1'b1;
                err_m = sat_inc(err_m);
                push_ev(EV_FALL, r, d, xfer_m, err_m, 1'b1);
                push_ev(EV_TERR, r, d, xfer_m, err_m, 1'b1);
            end
            // First cycle with ack low at or after release entry.
            l = (r >= ack_a && r < ack_a + w) ? ack_a + w : r;
            if (l - r < T) begin
                f = l + 1;
                if (!abort_m) begin
                    xfer_m = sat_inc(xfer_m);
                    push_ev(EV_DONE, f, d, xfer_m, err_m, 1'b0);
                end
            end else begin
                f = r + T;
                err_m = sat_inc(err_m);
                push_ev(EV_TERR, f, d, xfer_m, err_m, 1'b0);
            end
            push_ev(EV_BFALL, f, d, xfer_m, err_m, 1'b0);

            sn = ((f > ack_a + w) ? f : ack_a + w) + $urandom_range(0, 2);
            while (cyc < sn) begin
                start = (cyc == s) || (cyc > s && cyc < f && $urandom_range(0, 3) == 0);
                din   = (cyc == s) ? d : DW'($urandom);
                ack   = (cyc >= ack_a && cyc < ack_a + w);
                @(posedge clk); #1;
            end
            s = sn;
        end
        start = 1'b0; ack = 1'b0;
        @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Reset in the 5th ASSERT cycle: req drops at once, nothing reported.
        start = 1'b1; din = 8'h3C; ack = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("midrst_req_before",  32'(req), 1);
        check("midrst_dout_before", 32'(dout), 32'h3C);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_req",  32'(req), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_dout", 32'(dout), 0);
        check("midrst_terr", 32'(timeout_err), 0);
        check("midrst_xfer", 32'(xfer_cnt), 0);
        check("midrst_err",  32'(err_cnt), 0);
        for (int k = 0; k < T + 2; k++) begin
            @(posedge clk); #1;
            check("postrst_terr", 32'(timeout_err), 0);
            check("postrst_req",  32'(req), 0);
            check("postrst_done", 32'(done), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
